calc_operand_sequencer: RTL and testbench
=========================================

Name: calc_operand_sequencer

Overview:
Clocked, parametrised successor to the calculator operand/opcode capture stage. Captures operand 1, the operation code and operand 2 from the switches in sequence on debounced Enter presses, under its own stage FSM. Supports Back-stepping, skips operand 2 for unary opcodes, and holds a valid result set for the ALU until acknowledged. Sits between the debounced button/switch inputs and the calculator ALU/display.

Parameters:
WIDTH, 16, operand width in bits
OPW, 3, operation code width in bits
UNARY_MASK, {2**OPW{1'b0}}, bit k set = opcode k is unary (operand 2 not collected)

Ports:
IN_clk  in  1  system clock; all state updates on rising edge
IN_reset  in  1  asynchronous, active-high reset
IN_switches  in  WIDTH  operand source
IN_operation_code  in  OPW  opcode source
IN_enter  in  1  debounced Enter level; rising edge detected internally
IN_back  in  1  debounced Back level; rising edge detected internally
IN_ack  in  1  ALU consumed the operand set; level, sampled in DONE only
OUT_num1  out  WIDTH  captured operand 1
OUT_num2  out  WIDTH  captured operand 2 (0 for unary ops)
OUT_operation_code  out  OPW  captured opcode
OUT_stage  out  2  0=NUM1, 1=OP, 2=NUM2, 3=DONE
OUT_valid  out  1  high while stage==DONE
OUT_unary  out  1  UNARY_MASK[captured opcode]

Behaviour:
- Reset (async, immediate, also mid-sequence): OUT_num1/num2/operation_code=0, OUT_unary=0, stage=NUM1, OUT_valid=0; edge-history flops for IN_enter/IN_back reset to 1, so a button held through reset release does not fire.
- enter_rise = IN_enter & ~enter_q; back_rise = IN_back & ~back_q; history flops sample inputs every cycle.
- All outputs registered; a capture at edge k is visible after edge k (one-cycle latency from the first high sample).
- NUM1: enter_rise -> num1<=IN_switches, stage OP.
- OP: enter_rise -> op<=IN_operation_code, unary<=UNARY_MASK[IN_operation_code]; if unary: num2<=0, stage DONE; else stage NUM2.
- NUM2: enter_rise -> num2<=IN_switches, stage DONE.
- DONE: OUT_valid=1; enter_rise ignored; IN_ack=1 -> stage NUM1; captured values retained until overwritten.
- back_rise: NUM1 no effect; OP->NUM1; NUM2->OP; DONE-> OP if unary else NUM2. Back never modifies captured registers.
- Priority: back_rise over enter_rise in the same cycle; in DONE, IN_ack over back_rise.
- IN_ack outside DONE ignored.
- Held Enter/Back produces exactly one event per press; release and re-press required.
- Registers not being captured hold their value every cycle.
- Widths exact; no truncation or extension of switch data (WIDTH-bit capture).

Test Plan:
- Reset, then enter edge with switches=16'h1234, enter edge with op=3'd2, enter edge with switches=16'h00FF -> num1=1234, op=2, num2=00FF, stage=3, valid=1; ack=1 -> stage=0, values held.
- UNARY_MASK=8'h80, num1=16'hABCD, op=7 -> stage goes OP->DONE directly, num2=0, unary=1; back edge in DONE -> stage=1.
- Enter held high 20 cycles in NUM1 -> exactly one capture, stage=1 only; second capture after release and re-press.
- Enter and back rise same cycle in NUM2 -> stage=1, num2 unchanged; back edge in NUM1 -> no change.
- Assert IN_reset asynchronously mid-NUM2 with enter held high -> outputs 0 immediately, stage=0, no capture after reset release until Enter is released and re-pressed.
- IN_ack=1 in NUM1/OP/NUM2 -> no effect; ack and back together in DONE -> stage=0.

Source files
------------

// File: rtl/calc_operand_sequencer.sv
`default_nettype none
// ============================================================================
// calc_operand_sequencer : captures operand 1, opcode and operand 2 on Enter
// presses, with Back-stepping, unary skip and an ack-released result hold.
// Revision: 1.0
// ============================================================================
module calc_operand_sequencer #(
  parameter int                  WIDTH      = 16,
  parameter int                  OPW        = 3,
  parameter logic [2**OPW-1:0]   UNARY_MASK = '0
) (
  input  logic             IN_clk,
  input  logic             IN_reset,
  input  logic [WIDTH-1:0] IN_switches,
  input  logic [OPW-1:0]   IN_operation_code,
  input  logic             IN_enter,
  input  logic             IN_back,
  input  logic             IN_ack,
  output logic [WIDTH-1:0] OUT_num1,
  output logic [WIDTH-1:0] OUT_num2,
  output logic [OPW-1:0]   OUT_operation_code,
  output logic [1:0]       OUT_stage,
  output logic             OUT_valid,
  output logic             OUT_unary
);

  typedef enum logic [1:0] {
    S_NUM1 = 2'd0,
    S_OP   = 2'd1,
    S_NUM2 = 2'd2,
    S_DONE = 2'd3
  } stage_t;

  stage_t           stage_q, stage_d;
  logic             enter_q, back_q;
  logic [WIDTH-1:0] num1_q, num2_q;
  logic [OPW-1:0]   op_q;
  logic             unary_q, valid_q;
  logic             enter_rise, back_rise, op_is_unary;

  assign enter_rise  = IN_enter & ~enter_q;
  assign back_rise   = IN_back  & ~back_q;
  assign op_is_unary = UNARY_MASK[IN_operation_code];

  // Back outranks Enter everywhere; in DONE the ALU ack outranks Back.
  always_comb begin
    stage_d = stage_q;
    case (stage_q)
      S_NUM1: if (!back_rise && enter_rise) stage_d = S_OP;
      S_OP: begin
        if (back_rise)       stage_d = S_NUM1;
        else if (enter_rise) stage_d = op_is_unary ? S_DONE : S_NUM2;
      end
      S_NUM2: begin
        if (back_rise)       stage_d = S_OP;
        else if (enter_rise) stage_d = S_DONE;
      end
      S_DONE: begin
        if (IN_ack)          stage_d = S_NUM1;
        else if (back_rise)  stage_d = unary_q ? S_OP : S_NUM2;
      end
      default:               stage_d = S_NUM1;
    endcase
  end

  // History flops reset high so a button held across reset release stays quiet.
  always_ff @(posedge IN_clk or posedge IN_reset) begin
    if (IN_reset) begin
      stage_q <= S_NUM1;
      enter_q <= 1'b1;
      back_q  <= 1'b1;
      num1_q  <= '0;
      num2_q  <= '0;
      op_q    <= '0;
      unary_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      enter_q <= IN_enter;
      back_q  <= IN_back;
      stage_q <= stage_d;
      valid_q <= (stage_d == S_DONE);
      if (!back_rise && enter_rise) begin
        case (stage_q)
          S_NUM1: num1_q <= IN_switches;
          S_OP: begin
            op_q    <= IN_operation_code;
            unary_q <= op_is_unary;
            if (op_is_unary) num2_q <= '0;
          end
          S_NUM2: num2_q <= IN_switches;
          default: ;
        endcase
      end
    end
  end

  assign OUT_num1           = num1_q;
  assign OUT_num2           = num2_q;
  assign OUT_operation_code = op_q;
  assign OUT_stage          = stage_q;
  assign OUT_valid          = valid_q;
  assign OUT_unary          = unary_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_operand_sequencer.sv
`default_nettype none
// Scoreboard bench for calc_operand_sequencer: a stage-rule reference model
// queues expected outputs per clock, a negedge monitor pops and compares.
module tb_calc_operand_sequencer;

  localparam logic [7:0] MASK = 8'h82;  // opcodes 1 and 7 are unary

  logic        IN_clk = 1'b0;
  logic        IN_reset, IN_enter, IN_back, IN_ack;
  logic [15:0] IN_switches;
  logic [2:0]  IN_operation_code;
  logic [15:0] OUT_num1, OUT_num2;
  logic [2:0]  OUT_operation_code;
  logic [1:0]  OUT_stage;
  logic        OUT_valid, OUT_unary;

  calc_operand_sequencer #(.WIDTH(16), .OPW(3), .UNARY_MASK(MASK)) dut (
    .IN_clk(IN_clk), .IN_reset(IN_reset), .IN_switches(IN_switches),
    .IN_operation_code(IN_operation_code), .IN_enter(IN_enter),
    .IN_back(IN_back), .IN_ack(IN_ack), .OUT_num1(OUT_num1),
    .OUT_num2(OUT_num2), .OUT_operation_code(OUT_operation_code),
    .OUT_stage(OUT_stage), .OUT_valid(OUT_valid), .OUT_unary(OUT_unary));

  always #5 IN_clk = ~IN_clk;

  typedef struct packed {
    logic [15:0] n1;
    logic [15:0] n2;
    logic [2:0]  op;
    logic [1:0]  st;
    logic        v;
    logic        u;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: stage as a number 0..3, previous button levels.
  logic [15:0] m_n1, m_n2;
  logic [2:0]  m_op;
  int          m_st;
  logic        m_u, m_pe, m_pb;

  function automatic void model_reset();
    m_n1 = '0; m_n2 = '0; m_op = '0; m_st = 0; m_u = 1'b0;
    m_pe = 1'b1; m_pb = 1'b1;
  endfunction

  function automatic void model_clock(input logic en, input logic bk, input logic ack,
                                      input logic [15:0] sw, input logic [2:0] op);
    logic er, br;
    er = en && !m_pe;
    br = bk && !m_pb;
    m_pe = en;
    m_pb = bk;
    if (m_st == 3) begin
      if (ack)     m_st = 0;
      else if (br) m_st = m_u ? 1 : 2;
    end else if (br) begin
      m_st = (m_st == 0) ? 0 : m_st - 1;
    end else if (er) begin
      if (m_st == 0) begin
        m_n1 = sw; m_st = 1;
      end else if (m_st == 1) begin
        m_op = op; m_u = MASK[op];
        if (m_u) begin m_n2 = '0; m_st = 3; end
        else m_st = 2;
      end else begin
        m_n2 = sw; m_st = 3;
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.n1 = m_n1; e.n2 = m_n2; e.op = m_op; e.st = 2'(m_st);
    e.v = (m_st == 3); e.u = m_u;
    return e;
  endfunction

  task automatic step(input logic en, input logic bk, input logic ack,
                      input logic [15:0] sw, input logic [2:0] op);
    IN_enter = en; IN_back = bk; IN_ack = ack;
    IN_switches = sw; IN_operation_code = op;
    @(posedge IN_clk);
    model_clock(en, bk, ack, sw, op);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare every cycle the DUT presents a registered output set.
  always @(negedge IN_clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {OUT_num1, OUT_num2, OUT_operation_code, OUT_stage, OUT_valid, OUT_unary};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t actual n1=%h n2=%h op=%0d st=%0d v=%b u=%b required n1=%h n2=%h op=%0d st=%0d v=%b u=%b",
                 $time, a.n1, a.n2, a.op, a.st, a.v, a.u, e.n1, e.n2, e.op, e.st, e.v, e.u);
      end
    end
  end

  initial begin
    logic [31:0] r;
    int          wait_cnt;
    IN_reset = 1'b1; IN_enter = 1'b0; IN_back = 1'b0; IN_ack = 1'b0;
    IN_switches = '0; IN_operation_code = '0;
    model_reset();
    repeat (2) @(negedge IN_clk);
    check("reset_num1", 32'(OUT_num1), 32'h0);
    check("reset_num2", 32'(OUT_num2), 32'h0);
    check("reset_stage", 32'(OUT_stage), 32'd0);
    check("reset_valid", 32'(OUT_valid), 32'd0);
    check("reset_unary", 32'(OUT_unary), 32'd0);
    IN_reset = 1'b0;

    // Binary sequence, then ack.
    step(0, 0, 0, 16'h0000, 3'd0);
    step(1, 0, 0, 16'h1234, 3'd0);
    step(0, 0, 0, 16'h0000, 3'd0);
    step(1, 0, 0, 16'h0000, 3'd2);
    step(0, 0, 0, 16'h0000, 3'd0);
    step(1, 0, 0, 16'h00FF, 3'd0);
    step(0, 0, 0, 16'h0000, 3'd0);
    check("seq_num1", 32'(OUT_num1), 32'h1234);
    check("seq_op", 32'(OUT_operation_code), 32'd2);
    check("seq_num2", 32'(OUT_num2), 32'h00FF);
    check("seq_stage_done", 32'(OUT_stage), 32'd3);
    check("seq_valid", 32'(OUT_valid), 32'd1);
    step(0, 0, 1, 16'h0000, 3'd0);
    check("ack_stage", 32'(OUT_stage), 32'd0);
    check("ack_hold_num1", 32'(OUT_num1), 32'h1234);

    // Unary opcode skips operand 2; Back in DONE returns to OP.
    step(1, 0, 0, 16'hABCD, 3'd0);
    step(0, 0, 0, 16'h0000, 3'd0);
    step(1, 0, 0, 16'hFFFF, 3'd7);
    check("unary_stage", 32'(OUT_stage), 32'd3);
    check("unary_num2", 32'(OUT_num2), 32'h0);
    check("unary_flag", 32'(OUT_unary), 32'd1);
    step(0, 0, 0, 16'h0000, 3'd0);
    step(0, 1, 0, 16'h0000, 3'd0);
    check("unary_back", 32'(OUT_stage), 32'd1);
    step(0, 0, 0, 16'h0000, 3'd0);
    step(0, 1, 0, 16'h0000, 3'd0);
    step(0, 0, 0, 16'h0000, 3'd0);

    // Enter held: one capture only, data changes ignored while held.
    step(1, 0, 0, 16'h1111, 3'd0);
    for (int i = 0; i < 19; i++) begin
      r = $urandom;
      step(1, 0, 0, r[15:0], 3'd0);
    end
    check("held_stage", 32'(OUT_stage), 32'd1);
    check("held_num1", 32'(OUT_num1), 32'h1111);
    step(0, 0, 0, 16'h0000, 3'd0);
    step(1, 0, 0, 16'h0000, 3'd3);
    check("repress_stage", 32'(OUT_stage), 32'd2);

    // Enter and Back together in NUM2: Back wins.
    step(0, 0, 0, 16'h0000, 3'd0);
    step(1, 1, 0, 16'h7777, 3'd0);
    check("both_stage", 32'(OUT_stage), 32'd1);
    check("both_num2", 32'(OUT_num2), 32'h0);
    step(0, 0, 0, 16'h0000, 3'd0);
    step(0, 1, 0, 16'h0000, 3'd0);
    step(0, 0, 0, 16'h0000, 3'd0);
    step(0, 1, 0, 16'h0000, 3'd0);
    check("back_in_num1", 32'(OUT_stage), 32'd0);
    step(0, 0, 0, 16'h0000, 3'd0);

    // Async reset mid-NUM2 with Enter held high.
    step(1, 0, 0, 16'h2222, 3'd0);
    step(0, 0, 0, 16'h0000, 3'd0);
    step(1, 0, 0, 16'h0000, 3'd4);
    step(0, 0, 0, 16'h0000, 3'd0);
    @(negedge IN_clk);
    IN_enter = 1'b1; IN_switches = 16'h3333;
    #2 IN_reset = 1'b1;
    #1;
    check("async_num1", 32'(OUT_num1), 32'h0);
    check("async_op", 32'(OUT_operation_code), 32'h0);
    check("async_stage", 32'(OUT_stage), 32'd0);
    model_reset();
    @(posedge IN_clk);
    @(negedge IN_clk);
    IN_reset = 1'b0;
    step(1, 0, 0, 16'h3333, 3'd0);
    step(1, 0, 0, 16'h3333, 3'd0);
    check("held_reset_stage", 32'(OUT_stage), 32'd0);
    step(0, 0, 0, 16'h0000, 3'd0);
    step(1, 0, 0, 16'h5A5A, 3'd0);
    check("post_reset_num1", 32'(OUT_num1), 32'h5A5A);

    // Ack ignored outside DONE; ack beats Back in DONE.
    step(0, 0, 1, 16'h0000, 3'd0);
    step(1, 0, 1, 16'h0000, 3'd4);
    step(0, 0, 1, 16'h0000, 3'd0);
    check("ack_ignored", 32'(OUT_stage), 32'd2);
    step(1, 0, 0, 16'h4444, 3'd0);
    step(0, 1, 1, 16'h0000, 3'd0);
    check("ack_over_back", 32'(OUT_stage), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic en, bk, ak;
      r  = $urandom;
      en = ($urandom_range(0, 9) < 4);
      bk = ($urandom_range(0, 9) < 1);
      ak = ($urandom_range(0, 3) == 0);
      step(en, bk, ak, r[15:0], r[18:16]);
    end
    step(0, 0, 0, 16'h0000, 3'd0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge IN_clk);
      wait_cnt++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
